// File: rtl/shift_issue.sv
// Initiator-side controller for the multi-cycle shift unit.
// Accepts one shift op, kicks the unit, collects the result and offers it
// to writeback; busy stalls the pipeline while an op is in flight.
module shift_issue #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned RD_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  input  logic             flush,
  output logic             sh_kick,
  output logic             sh_lshift,
  output logic             sh_unsigned,
  output logic [WIDTH-1:0] sh_a,
  output logic [WIDTH-1:0] sh_b,
  input  logic             sh_ready,
  input  logic             sh_done,
  input  logic [WIDTH-1:0] sh_q,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_DRAIN,
    S_WB
  } state_t;

  state_t state;
  state_t state_next;

  logic               accept;
  logic               bypass;
  logic               capture;
  logic               guard;
  logic               done_ok;
  logic [SHAMT_W-1:0] shamt;
  logic               unused_req_b;

  // Only the low shamt bits of req_b are meaningful.
  assign shamt        = req_b[SHAMT_W-1:0];
  assign unused_req_b = ^req_b[WIDTH-1:SHAMT_W];

  // A done seen in the first cycle after a kick may be the previous op's sticky done.
  assign done_ok = sh_done && !guard;

  assign busy     = (state != S_IDLE);
  assign wb_valid = (state == S_WB);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, handshake and kick decode.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    bypass     = 1'b0;
    capture    = 1'b0;
    sh_kick    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          accept = 1'b1;
          if ((shamt == '0) || (req_op == OP_RSV)) begin
            bypass     = 1'b1;
            state_next = S_WB;
          end else begin
            state_next = S_KICK;
          end
        end
      end
      S_KICK: begin
        if (flush) begin
          state_next = S_IDLE;
        end else if (sh_ready) begin
          sh_kick    = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_next = S_DRAIN;
        end else if (done_ok) begin
          capture    = 1'b1;
          state_next = S_WB;
        end
      end
      S_DRAIN: begin
        if (done_ok) begin
          state_next = S_IDLE;
        end
      end
      S_WB: begin
        if (flush || wb_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Op latch, stale-done guard and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_a        <= '0;
      sh_b        <= '0;
      sh_lshift   <= 1'b0;
      sh_unsigned <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      guard       <= 1'b0;
    end else begin
      guard <= sh_kick;
      if (accept) begin
        sh_a        <= req_a;
        sh_b        <= WIDTH'(shamt);
        sh_lshift   <= (req_op == OP_SLL);
        sh_unsigned <= (req_op == OP_SRL);
        wb_rd       <= req_rd;
      end
      if (bypass) begin
        wb_data <= (req_op == OP_RSV) ? '0 : req_a;
      end else if (capture) begin
        wb_data <= sh_q;
      end
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with a behavioural multi-cycle shift unit.
module tb_shift_issue;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        sh_kick;
  logic        sh_lshift;
  logic        sh_unsigned;
  logic [31:0] sh_a;
  logic [31:0] sh_b;
  logic        sh_ready;
  logic        sh_done;
  logic [31:0] sh_q;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int kick_cnt = 0;

  shift_issue #(.WIDTH(32), .SHAMT_W(5), .RD_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .sh_kick(sh_kick), .sh_lshift(sh_lshift), .sh_unsigned(sh_unsigned),
    .sh_a(sh_a), .sh_b(sh_b), .sh_ready(sh_ready), .sh_done(sh_done),
    .sh_q(sh_q), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift unit: done rises n cycles after the kick cycle and is cleared
  // lazily, one cycle after the kick edge (so it looks stale to a new op).
  logic [31:0] u_cnt;
  logic [31:0] u_res;
  logic        u_kick_d;

  assign sh_ready = (u_cnt == 32'd0);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_cnt    <= 32'd0;
      u_res    <= 32'd0;
      u_kick_d <= 1'b0;
      sh_done  <= 1'b0;
      sh_q     <= 32'd0;
    end else begin
      u_kick_d <= sh_kick;
      if (u_kick_d) sh_done <= 1'b0;
      if (sh_kick) begin
        u_cnt <= sh_b - 32'd1;
        if (sh_lshift) u_res <= sh_a << sh_b[4:0];
        else if (sh_unsigned) u_res <= sh_a >> sh_b[4:0];
        else u_res <= 32'($signed(sh_a) >>> sh_b[4:0]);
      end else if (u_cnt != 32'd0) begin
        u_cnt <= u_cnt - 32'd1;
        if (u_cnt == 32'd1) begin
          sh_done <= 1'b1;
          sh_q    <= u_res;
        end
      end
    end
  end

  always @(posedge clk) if (sh_kick === 1'b1) kick_cnt++;

  // Present one op for one accept edge; returns at the first cycle after it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Cycles from the accept cycle until wb_valid is seen (-1 on timeout).
  task automatic wait_wb(output int lat);
    lat = 1;
    while (wb_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (wb_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
    req_rd = '0; flush = 1'b0; wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, wb_valid, sh_kick, sh_lshift, sh_unsigned} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, wb_valid, sh_kick, sh_lshift, sh_unsigned});
    end
    checks++;
    if ({sh_a, sh_b, wb_data, wb_rd} !== 101'd0) begin
      failures++;
      $display("FAIL reset_data: got a=%h b=%h d=%h rd=%h expected all 0", sh_a, sh_b, wb_data, wb_rd);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_sll();
    int lat;
    int k0;
    k0 = kick_cnt;
    issue(2'b00, 32'h1, 32'd4, 5'd3);
    checks++;
    if ({sh_kick, sh_lshift, busy} !== 3'b111 || sh_b !== 32'd4) begin
      failures++;
      $display("FAIL sll_kick: got kick=%b lsh=%b busy=%b b=%h expected 1 1 1 4", sh_kick, sh_lshift, busy, sh_b);
    end
    wait_wb(lat);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL sll_latency: got %0d expected 6", lat); end
    checks++;
    if (wb_data !== 32'h10 || wb_rd !== 5'd3) begin
      failures++;
      $display("FAIL sll_result: got %h rd=%0d expected 00000010 rd=3", wb_data, wb_rd);
    end
    checks++;
    if (kick_cnt - k0 !== 1) begin failures++; $display("FAIL sll_kick_count: got %0d expected 1", kick_cnt - k0); end
  endtask

  task automatic test_sra_srl();
    int lat;
    issue(2'b10, 32'h8000_0000, 32'd31, 5'd5);
    checks++;
    if ({sh_lshift, sh_unsigned} !== 2'b00) begin
      failures++;
      $display("FAIL sra_map: got %b expected 00", {sh_lshift, sh_unsigned});
    end
    wait_wb(lat);
    checks++;
    if (lat !== 33 || wb_data !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sra_result: got lat=%0d %h expected lat=33 ffffffff", lat, wb_data);
    end
    issue(2'b01, 32'h8000_0000, 32'd31, 5'd6);
    checks++;
    if ({sh_lshift, sh_unsigned} !== 2'b01) begin
      failures++;
      $display("FAIL srl_map: got %b expected 01", {sh_lshift, sh_unsigned});
    end
    wait_wb(lat);
    checks++;
    if (lat !== 33 || wb_data !== 32'h1 || wb_rd !== 5'd6) begin
      failures++;
      $display("FAIL srl_result: got lat=%0d %h rd=%0d expected lat=33 00000001 rd=6", lat, wb_data, wb_rd);
    end
  endtask

  task automatic test_shamt_zero();
    int k0;
    k0 = kick_cnt;
    issue(2'b00, 32'h1234, 32'h20, 5'd7);
    checks++;
    if (sh_kick !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'h1234 || wb_rd !== 5'd7) begin
      failures++;
      $display("FAIL shamt0: got kick=%b v=%b %h rd=%0d expected 0 1 00001234 rd=7", sh_kick, wb_valid, wb_data, wb_rd);
    end
    issue(2'b11, 32'hDEAD, 32'd4, 5'd8);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_rd !== 5'd8) begin
      failures++;
      $display("FAIL op_reserved: got v=%b %h rd=%0d expected 1 00000000 rd=8", wb_valid, wb_data, wb_rd);
    end
    @(negedge clk);
    checks++;
    if (kick_cnt !== k0) begin failures++; $display("FAIL bypass_no_kick: got %0d kicks expected 0", kick_cnt - k0); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    wb_ready = 1'b0;
    issue(2'b01, 32'hF000, 32'd8, 5'd9);
    wait_wb(lat);
    checks++;
    if (lat !== 10 || wb_data !== 32'hF0) begin
      failures++;
      $display("FAIL stall_first: got lat=%0d %h expected lat=10 000000f0", lat, wb_data);
    end
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h3; req_b = 32'd5; req_rd = 5'd12;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_data !== 32'hF0 || wb_rd !== 5'd9 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
    wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake_no_accept: got v=%b rdy=%b expected 0 1", wb_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_wb(lat);
    checks++;
    if (lat !== 7 || wb_data !== 32'h60 || wb_rd !== 5'd12) begin
      failures++;
      $display("FAIL stale_done: got lat=%0d %h rd=%0d expected lat=7 00000060 rd=12", lat, wb_data, wb_rd);
    end
  endtask

  task automatic test_flush();
    int k0;
    int k;
    logic seen;
    k0 = kick_cnt;
    issue(2'b00, 32'h1, 32'd3, 5'd2);
    flush = 1'b1;
    #1;
    checks++;
    if (sh_kick !== 1'b0) begin failures++; $display("FAIL flush_kick: got %b expected 0", sh_kick); end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || kick_cnt !== k0) begin
      failures++;
      $display("FAIL flush_kick_idle: got busy=%b kicks=%0d expected 0 0", busy, kick_cnt - k0);
    end
    issue(2'b00, 32'h1, 32'd6, 5'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    k = 3;
    seen = 1'b0;
    while (req_ready !== 1'b1 && k < 100) begin
      if (wb_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 8 || seen !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_drain: got ready_at=%0d wb_seen=%b busy=%b expected 8 0 0", k, seen, busy);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat;
    issue(2'b00, 32'h1, 32'd10, 5'd4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, wb_valid, sh_kick} !== 3'b000) begin
      failures++;
      $display("FAIL reset_wait: got %b expected 000", {busy, wb_valid, sh_kick});
    end
    @(negedge clk);
    reset = 1'b1;
    issue(2'b01, 32'hF0, 32'd4, 5'd9);
    wait_wb(lat);
    checks++;
    if (lat !== 6 || wb_data !== 32'h0F || wb_rd !== 5'd9) begin
      failures++;
      $display("FAIL after_reset: got lat=%0d %h rd=%0d expected lat=6 0000000f rd=9", lat, wb_data, wb_rd);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_shamt_zero();
    test_back_to_back();
    test_flush();
    test_reset_in_wait();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
